// File: rtl/rio_uart_pkg.sv
// Shared definitions for the UART frame receiver: FSM states, default header and checksum helper.
package rio_uart_pkg;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    PAYLOAD = 2'd1,
    CHECK   = 2'd2
  } rxState_e;

  localparam logic [31:0] DEFAULT_HEADER = 32'h74697277;
  localparam int          HEADER_LEN     = 4;

  // Running modulo-256 payload checksum.
  function automatic logic [7:0] csumAdd(input logic [7:0] sum, input logic [7:0] data);
    return sum + data;
  endfunction

endpackage

// File: rtl/uart_frame_rx.sv
// Frame receiver: sliding header hunt, payload capture into a staging register,
// checksum verification, and registered result/status pulses.
module uart_frame_rx
  import rio_uart_pkg::*;
#(
  parameter int          BUFFER_SIZE = 128,
  parameter logic [31:0] HEADER      = DEFAULT_HEADER
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rx_valid,
  input  logic [7:0]             rx_data,
  input  logic                   rx_eop,
  output logic [BUFFER_SIZE-1:0] data_out,
  output logic                   frame_valid,
  output logic                   err_checksum,
  output logic                   err_short,
  output logic [15:0]            frame_count
);

  localparam int NBYTES = BUFFER_SIZE / 8;
  localparam int IDXW   = $clog2(NBYTES) + 1;
  localparam int WINW   = 8 * HEADER_LEN;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);

  rxState_e               stateR, stateNextS;
  logic [WINW-1:0]        windowR, windowNextS, shiftedS;
  logic [IDXW-1:0]        idxR, idxNextS;
  logic [7:0]             sumR, sumNextS;
  logic [BUFFER_SIZE-1:0] stagingR, stagingNextS;
  logic [BUFFER_SIZE-1:0] dataOutNextS;
  logic                   frameValidNextS, errChecksumNextS, errShortNextS;
  logic [15:0]            frameCountNextS;
  logic                   frameDoneS;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      stateR <= HUNT;
    end else begin
      stateR <= stateNextS;
    end
  end

  // Next-state, datapath and output-pulse decode; the byte is handled before any end-of-packet abort.
  always_comb begin
    stateNextS       = stateR;
    windowNextS      = windowR;
    idxNextS         = idxR;
    sumNextS         = sumR;
    stagingNextS     = stagingR;
    dataOutNextS     = data_out;
    frameValidNextS  = 1'b0;
    errChecksumNextS = 1'b0;
    errShortNextS    = 1'b0;
    frameCountNextS  = frame_count;
    frameDoneS       = 1'b0;
    shiftedS         = (windowR << 8) | {{(WINW-8){1'b0}}, rx_data};

    case (stateR)
      HUNT: begin
        if (rx_valid) begin
          windowNextS = shiftedS;
          if (shiftedS == HEADER) begin
            stateNextS = PAYLOAD;
            idxNextS   = {IDXW{1'b0}};
            sumNextS   = 8'd0;
          end else begin
            stateNextS = HUNT;
          end
        end else begin
          stateNextS = HUNT;
        end
      end
      PAYLOAD: begin
        if (rx_valid) begin
          stagingNextS[BUFFER_SIZE - 8 - 8 * int'(idxR) +: 8] = rx_data;
          sumNextS = csumAdd(sumR, rx_data);
          idxNextS = idxR + IDXW'(1'b1);
          if (idxR == LAST_IDX) begin
            stateNextS = CHECK;
          end else begin
            stateNextS = PAYLOAD;
          end
        end else begin
          stateNextS = PAYLOAD;
        end
      end
      CHECK: begin
        if (rx_valid) begin
          frameDoneS  = 1'b1;
          windowNextS = {WINW{1'b0}};
          stateNextS  = HUNT;
          if (rx_data == sumR) begin
            dataOutNextS    = stagingR;
            frameValidNextS = 1'b1;
            frameCountNextS = frame_count + 16'd1;
          end else begin
            errChecksumNextS = 1'b1;
          end
        end else begin
          stateNextS = CHECK;
        end
      end
      default: begin
        stateNextS  = HUNT;
        windowNextS = {WINW{1'b0}};
      end
    endcase

    // A completed frame swallows a coincident end-of-packet; otherwise the gap aborts any frame in flight.
    if (rx_eop && !frameDoneS) begin
      windowNextS = {WINW{1'b0}};
      if (stateNextS != HUNT) begin
        errShortNextS = 1'b1;
      end else begin
        errShortNextS = 1'b0;
      end
      stateNextS = HUNT;
    end else begin
      frameDoneS = frameDoneS;
    end
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      windowR      <= {WINW{1'b0}};
      idxR         <= {IDXW{1'b0}};
      sumR         <= 8'd0;
      stagingR     <= {BUFFER_SIZE{1'b0}};
      data_out     <= {BUFFER_SIZE{1'b0}};
      frame_valid  <= 1'b0;
      err_checksum <= 1'b0;
      err_short    <= 1'b0;
      frame_count  <= 16'd0;
    end else begin
      windowR      <= windowNextS;
      idxR         <= idxNextS;
      sumR         <= sumNextS;
      stagingR     <= stagingNextS;
      data_out     <= dataOutNextS;
      frame_valid  <= frameValidNextS;
      err_checksum <= errChecksumNextS;
      err_short    <= errShortNextS;
      frame_count  <= frameCountNextS;
    end
  end

endmodule

// File: tb/tb_uart_frame_rx.sv
// Self-checking bench for uart_frame_rx: directed frames plus randomized streams
// compared every cycle against a byte-queue reference model.
module tb_uart_frame_rx;

  localparam int          BS  = 32;
  localparam int          N   = BS / 8;
  localparam logic [31:0] HDR = 32'h74697277;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_eop = 1'b0;
  logic [BS-1:0] data_out;
  logic          frame_valid, err_checksum, err_short;
  logic [15:0]   frame_count;

  uart_frame_rx #(.BUFFER_SIZE(BS), .HEADER(HDR)) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data), .rx_eop(rx_eop),
    .data_out(data_out), .frame_valid(frame_valid), .err_checksum(err_checksum),
    .err_short(err_short), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  int cmpCount = 0;
  int errCount = 0;

  // reference model: hunting flag, header window, queue of bytes collected since the header
  bit          mHunt = 1'b1;
  logic [31:0] mWin  = 32'h0;
  logic [7:0]  mQ[$];
  logic [31:0] mDout = 32'h0;
  logic [15:0] mCnt  = 16'h0;
  bit          mFv = 1'b0, mEc = 1'b0, mEs = 1'b0;

  task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    cmpCount++;
    if (got !== exp) begin
      errCount++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic checkAll();
    checkEq("frame_valid", {63'd0, frame_valid}, {63'd0, mFv});
    checkEq("err_checksum", {63'd0, err_checksum}, {63'd0, mEc});
    checkEq("err_short", {63'd0, err_short}, {63'd0, mEs});
    checkEq("data_out", {32'd0, data_out}, {32'd0, mDout});
    checkEq("frame_count", {48'd0, frame_count}, {48'd0, mCnt});
  endtask

  task automatic modelStep(input bit r, input bit v, input logic [7:0] d, input bit e);
    logic [7:0] sum;
    bit done;
    mFv = 1'b0; mEc = 1'b0; mEs = 1'b0;
    done = 1'b0;
    if (r) begin
      mHunt = 1'b1; mWin = 32'h0; mQ.delete(); mDout = 32'h0; mCnt = 16'h0;
      return;
    end
    if (v) begin
      if (mHunt) begin
        mWin = {mWin[23:0], d};
        if (mWin == HDR) begin
          mHunt = 1'b0;
          mQ.delete();
        end
      end else begin
        mQ.push_back(d);
        if (mQ.size() == N + 1) begin
          sum = 8'h00;
          for (int i = 0; i < N; i++) sum = sum + mQ[i];
          if (sum == mQ[N]) begin
            mDout = 32'h0;
            for (int i = 0; i < N; i++) mDout = {mDout[23:0], mQ[i]};
            mFv = 1'b1;
            mCnt = mCnt + 16'd1;
          end else begin
            mEc = 1'b1;
          end
          mHunt = 1'b1; mWin = 32'h0; done = 1'b1;
        end
      end
    end
    if (e && !done) begin
      if (!mHunt) mEs = 1'b1;
      mHunt = 1'b1; mWin = 32'h0;
    end
  endtask

  // one clock: check outputs from the previous edge, then drive the next inputs
  task automatic cyc(input bit r, input bit v, input logic [7:0] d, input bit e);
    @(negedge clk);
    checkAll();
    rst = r; rx_valid = v; rx_data = v ? d : 8'h00; rx_eop = e;
    modelStep(r, v, d, e);
  endtask

  task automatic sendByte(input logic [7:0] d);
    repeat ($urandom_range(0, 1)) cyc(1'b0, 1'b0, 8'h00, 1'b0);
    cyc(1'b0, 1'b1, d, 1'b0);
  endtask

  task automatic sendHeader();
    logic [31:0] h;
    h = HDR;
    for (int i = 3; i >= 0; i--) sendByte(h[8*i +: 8]);
  endtask

  task automatic sendFrame(input logic [31:0] p, input logic [7:0] cs);
    sendHeader();
    for (int i = 3; i >= 0; i--) sendByte(p[8*i +: 8]);
    sendByte(cs);
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    logic [7:0]  bytes[$];
    logic [31:0] p;
    logic [7:0]  sum;
    int          abortAt;
    bit          aborted;

    // reset state
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    checkEq("reset_dout", {32'd0, data_out}, 64'h0);
    checkEq("reset_cnt", {48'd0, frame_count}, 64'h0);

    // good frame
    sendFrame(32'h11223344, 8'hAA);
    checkEq("good_fv", {63'd0, frame_valid}, 64'h1);
    checkEq("good_dout", {32'd0, data_out}, 64'h11223344);
    checkEq("good_cnt", {48'd0, frame_count}, 64'h1);
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    checkEq("good_fv_1cyc", {63'd0, frame_valid}, 64'h0);

    // bad checksum
    sendFrame(32'h11223344, 8'hAB);
    checkEq("badcs_err", {63'd0, err_checksum}, 64'h1);
    checkEq("badcs_dout", {32'd0, data_out}, 64'h11223344);
    checkEq("badcs_cnt", {48'd0, frame_count}, 64'h1);

    // garbage prefix, including a partial header start
    bytes = '{8'h00, 8'h74, 8'h74, 8'h69, 8'h72, 8'h77, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0A};
    foreach (bytes[i]) sendByte(bytes[i]);
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    checkEq("garbage_fv", {63'd0, frame_valid}, 64'h1);
    checkEq("garbage_dout", {32'd0, data_out}, 64'h01020304);

    // abort by end-of-packet mid payload, then a normal frame
    sendHeader();
    sendByte(8'h11);
    sendByte(8'h22);
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    checkEq("abort_short", {63'd0, err_short}, 64'h1);
    checkEq("abort_dout", {32'd0, data_out}, 64'h01020304);
    sendFrame(32'h55667788, 8'hBA);
    checkEq("after_abort_dout", {32'd0, data_out}, 64'h55667788);
    checkEq("after_abort_cnt", {48'd0, frame_count}, 64'h3);

    // reset mid-frame
    sendHeader();
    sendByte(8'h11);
    sendByte(8'h22);
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    checkEq("midrst_dout", {32'd0, data_out}, 64'h0);
    checkEq("midrst_cnt", {48'd0, frame_count}, 64'h0);
    checkEq("midrst_short", {63'd0, err_short}, 64'h0);
    sendFrame(32'h11223344, 8'hAA);
    checkEq("postrst_cnt", {48'd0, frame_count}, 64'h1);

    // randomized streams: garbage, aborts, bad checksums, eop coincident with checksum byte
    for (int it = 0; it < 60; it++) begin
      repeat ($urandom_range(0, 3)) sendByte(8'($urandom_range(0, 255)));
      sendHeader();
      abortAt = ($urandom_range(0, 4) == 0) ? $urandom_range(0, N) : -1;
      aborted = 1'b0;
      p = $urandom;
      sum = 8'h00;
      for (int i = 3; i >= 0; i--) begin
        if (!aborted && abortAt == 3 - i) begin
          cyc(1'b0, ($urandom_range(0, 1) == 1), p[8*i +: 8], 1'b1);
          aborted = 1'b1;
        end else if (!aborted) begin
          sendByte(p[8*i +: 8]);
          sum = sum + p[8*i +: 8];
        end
      end
      if (!aborted && abortAt == N) begin
        cyc(1'b0, 1'b0, 8'h00, 1'b1);
        aborted = 1'b1;
      end
      if (!aborted) begin
        if ($urandom_range(0, 3) == 0) sum = sum ^ 8'($urandom_range(1, 255));
        cyc(1'b0, 1'b1, sum, ($urandom_range(0, 3) == 0));
      end
      repeat ($urandom_range(0, 3)) cyc(1'b0, 1'b0, 8'h00, 1'b0);
    end

    // frame counter wrap
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    mCnt = 16'hFFFF;
    force dut.frame_count = 16'hFFFF;
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    release dut.frame_count;
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    sendFrame(32'hA1B2C3D4, 8'hA1 + 8'hB2 + 8'hC3 + 8'hD4);
    checkEq("wrap_fv", {63'd0, frame_valid}, 64'h1);
    checkEq("wrap_cnt", {48'd0, frame_count}, 64'h0);
    checkEq("wrap_dout", {32'd0, data_out}, 64'hA1B2C3D4);
    cyc(1'b0, 1'b0, 8'h00, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, errCount);
    $finish;
  end

endmodule

// File: doc/uart_frame_rx.md
UART_FRAME_RX -- requirements
Module: uart_frame_rx

Interface
REQ-001 SHALL have parameter BUFFER_SIZE, default 128, meaning payload width in bits (multiple of 8, 8..1024).
REQ-002 SHALL have parameter HEADER, default 32'h74697277, meaning 4-byte frame header, sent MSB byte first.
REQ-003 SHALL have port clk  input  1  single clock for all logic.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port rx_valid  input  1  one-cycle strobe: rx_data holds a received byte (driven from the UART receiver's data-ready output).
REQ-006 SHALL have port rx_data  input  8  received byte, valid only while rx_valid=1.
REQ-007 SHALL have port rx_eop  input  1  one-cycle end-of-packet strobe (line-idle gap detected).
REQ-008 SHALL have port data_out  output  BUFFER_SIZE  payload of the last good frame.
REQ-009 SHALL have port frame_valid  output  1  one-cycle pulse when data_out is updated.
REQ-010 SHALL have port err_checksum  output  1  one-cycle pulse on checksum mismatch.
REQ-011 SHALL have port err_short  output  1  one-cycle pulse on a frame aborted by rx_eop.
REQ-012 SHALL have port frame_count  output  16  count of good frames, wraps 16'hFFFF->0.

Function
REQ-013 Frame format SHALL be: 4 header bytes, N=BUFFER_SIZE/8 payload bytes, 1 checksum byte.
REQ-014 The checksum SHALL be the 8-bit modulo-256 sum of the N payload bytes (header excluded).
REQ-015 States SHALL be HUNT, PAYLOAD, CHECK.
REQ-016 HUNT: each rx_valid SHALL shift rx_data into a 32-bit window (new byte in the LSB); when the updated window equals HEADER, the next state SHALL be PAYLOAD, with the byte index and running sum cleared.
REQ-017 The header match SHALL be sliding: a header preceded by garbage bytes SHALL still be detected.
REQ-018 PAYLOAD: each rx_valid SHALL store the byte into a staging register at bits [BUFFER_SIZE-1-8*i -: 8] (first byte in the MSB), add it to the sum, and increment i; after byte N-1 the next state SHALL be CHECK.
REQ-019 CHECK: on rx_valid, if rx_data equals the sum, the block SHALL copy the staging register to data_out, pulse frame_valid, and increment frame_count; otherwise it SHALL pulse err_checksum. In both cases the next state SHALL be HUNT with the window cleared to 0.
REQ-020 Latency: frame_valid, data_out, and frame_count SHALL change on the clock edge following the checksum byte's rx_valid cycle (registered, 1 cycle).
REQ-021 rx_eop in PAYLOAD or CHECK SHALL pulse err_short, return to HUNT, and clear the window; data_out SHALL remain unchanged.
REQ-022 rx_eop in HUNT SHALL only clear the window.
REQ-023 When rx_valid and rx_eop occur in the same cycle, the byte SHALL be processed first; if that byte completes a frame (CHECK), rx_eop SHALL be ignored, otherwise the abort rule SHALL apply.
REQ-024 data_out SHALL never show a partially received payload.
REQ-025 All pulse outputs SHALL be registered and SHALL be high for exactly 1 cycle.
REQ-026 Cycles with rx_valid=0 SHALL not change the state, index, or sum.

Reset
REQ-027 rst=1 at a clock edge SHALL force state HUNT, window=0, index=0, sum=0, data_out=0, frame_valid=0, err_checksum=0, err_short=0, and frame_count=0.
REQ-028 Reset mid-frame SHALL discard the partial frame; no error pulse SHALL be generated.

Structure
REQ-029 State encodings, default HEADER, and header length (4) SHALL live in the shared package rio_uart_pkg.
REQ-030 The block SHALL be a single module with no sub-module; the index counter width SHALL be $clog2(BUFFER_SIZE/8)+1.

Verification (BUFFER_SIZE=32, HEADER=32'h74697277)
REQ-031 Good frame: 74 69 72 77 11 22 33 44 AA -> one frame_valid, data_out=32'h11223344, frame_count=1.
REQ-032 Bad checksum: same frame with last byte AB -> err_checksum once, data_out unchanged, frame_count unchanged.
REQ-033 Garbage prefix: 00 74 74 69 72 77 01 02 03 04 0A -> frame_valid, data_out=32'h01020304.
REQ-034 Abort: header + 11 22, then rx_eop -> err_short once; a following good frame is accepted normally.
REQ-035 rst asserted after header + 2 payload bytes -> all outputs 0, no pulses; the next good frame is accepted.
REQ-036 Wrap: preload 65535 good frames (or force the count), then one more good frame -> frame_count=0.
